timer_display_scan: RTL and testbench
=====================================

Name: timer_display_scan

Overview:
- Display-side consumer of the chess-timer countdown outputs: takes both players' minutes/seconds and drives the Nexys 4 eight-digit multiplexed 7-segment display.
- Player A shows as mm.ss on digits 7..4 and player B on digits 3..0.
- Marks the running player and blinks an expired player's digits.
- Sits between the two countdown instances and the board-level display pins.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz digit rate at 100 MHz).
- BLINK_FRAMES, 64, completed scan frames per blink half-period.
- TW, 6, width of each minute/second input.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- min_a  in  TW  player A minutes
- sec_a  in  TW  player A seconds
- min_b  in  TW  player B minutes
- sec_b  in  TW  player B seconds
- run_b  in  1  1 = player B clock running, 0 = player A
- expired_a  in  1  player A reached 00.00
- expired_b  in  1  player B reached 00.00
- an  out  8  digit anodes, active-low, one-hot-zero
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low

Behaviour:
- Reset values: an=8'hFF, seg=7'h7F, dp=1. All counters, the digit index, the blink phase and the snapshot registers are 0.
- Reset is asynchronous on assertion and synchronous on release. There is no glitch output during reset.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1.
  - Issues a one-cycle tick at terminal count, then wraps to 0.
- Digit index: 3-bit, increments on tick, 7 wraps to 0.
- Snapshot:
  - Captures all seven inputs in the cycle the index wraps 7 to 0, so one frame never mixes two time values.
  - The first frame after reset displays the reset snapshot (zeros).
- Frame counter:
  - Counts frames 0..BLINK_FRAMES-1.
  - Toggles blink phase at wrap.
  - Blink phase 1 = off-half.
- Digit value:
  - Ten = v/10, unit = v%10, computed by a comparison ladder against 10..50 (no divider).
  - Any snapshot value >59 displays as dash (seg=7'h3F) on both of its digits.
- Digit mapping:
  - 7 = min_a tens, 6 = min_a units, 5 = sec_a tens, 4 = sec_a units.
  - 3..0 = the same order for player B.
- Decimal point:
  - dp=0 on digit 6 when run_b=0, and on digit 2 when run_b=1. Otherwise dp=1.
  - Snapshot run_b is used.
- Blink: if the snapshot expired flag for a player is 1 and blink phase is 1, that player's four digits output seg=7'h7F and dp=1, with the anode still driven.
- Both expired: both halves blink in phase.
- Output latency:
  - an, seg and dp are registered and update in the cycle after tick.
  - an = ~(1<<index) for the new index.
  - Between ticks, outputs hold.
- Ghosting guard:
  - For one clk cycle after each tick, an=8'hFF.
  - The new anode asserts on the following cycle, with seg already settled.
- Inputs are assumed synchronous to clk. There is no handshake; the block is a pure reader.

Decomposition:
- Shared package chess_display_pkg holds:
  - the segment encodings for 0-9, dash and blank (active-low, 7-bit);
  - the digit-position constants (DIG_A_MT=7 .. DIG_B_SU=0);
  - the DASH and BLANK localparams.
- One combinational sub-module, seg7_decode: 4-bit code in, 7-bit active-low segments out. Codes 10 = dash and 15 = blank map to the package constants.
- The BCD ladder stays inline in timer_display_scan.

Test Plan:
- Reset, then release with REFRESH_DIV=4: an=8'hFF, seg=7'h7F, dp=1 throughout reset. The first anode 8'hFE appears 2 cycles after the first tick.
- Inputs min_a=12, sec_a=34, min_b=5, sec_b=9, run_b=0: over one frame, digits 7..0 show 1,2,3,4,0,5,0,9 (seg 7'h79, 7'h24, 7'h30, 7'h19, 7'h40, 7'h12, 7'h40, 7'h10). dp=0 only on digit 6.
- Change sec_a from 34 to 33 mid-frame: the current frame still shows 34 on digits 5/4. The next frame shows 33 after the 7 to 0 wrap.
- sec_b=60: digits 1 and 0 show dash (7'h3F). Other digits are unaffected.
- expired_a=1, BLINK_FRAMES=2: digits 7..4 alternate between values and blank (7'h7F) every 2 frames. Digits 3..0 stay steady.
- Assert rst_n=0 mid-frame: an=8'hFF immediately (asynchronous). After release, index and snapshot restart from 0.

Source files
------------

// File: rtl/chess_display_pkg.sv
// chess_display_pkg
//   Shared display constants for the chess-timer display path:
//   - active-low 7-segment encodings {g,f,e,d,c,b,a} for digits 0-9,
//     dash and blank;
//   - 4-bit decoder codes for dash and blank;
//   - digit-position names for the eight-digit scan (A on 7..4, B on 3..0).
package chess_display_pkg;

   localparam logic [6:0] DASH  = 7'h3F;
   localparam logic [6:0] BLANK = 7'h7F;

   localparam logic [3:0] CODE_DASH  = 4'd10;
   localparam logic [3:0] CODE_BLANK = 4'd15;

   localparam logic [6:0] SEG_LUT [10] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

   // Scan position of each displayed digit (M = minutes, S = seconds,
   // T = tens, U = units).
   typedef enum logic [2:0] {
      DIG_B_SU = 3'd0,
      DIG_B_ST = 3'd1,
      DIG_B_MU = 3'd2,
      DIG_B_MT = 3'd3,
      DIG_A_SU = 3'd4,
      DIG_A_ST = 3'd5,
      DIG_A_MU = 3'd6,
      DIG_A_MT = 3'd7
   } digit_pos_e;

endpackage

// File: rtl/timer_display_scan_if.sv
// timer_display_scan_if
//   Bundles the countdown-side time values and the display-pin outputs of
//   timer_display_scan.
//   master : the countdown side (drives times/flags, observes pins)
//   slave  : the display scanner (reads times/flags, drives pins)
interface timer_display_scan_if #(
   parameter int unsigned TW = 6
);
   logic [TW-1:0] min_a;
   logic [TW-1:0] sec_a;
   logic [TW-1:0] min_b;
   logic [TW-1:0] sec_b;
   logic          run_b;
   logic          expired_a;
   logic          expired_b;
   logic [7:0]    an;
   logic [6:0]    seg;
   logic          dp;

   modport master (
      output min_a, sec_a, min_b, sec_b, run_b, expired_a, expired_b,
      input  an, seg, dp
   );

   modport slave (
      input  min_a, sec_a, min_b, sec_b, run_b, expired_a, expired_b,
      output an, seg, dp
   );
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode
//   Combinational 4-bit code to active-low 7-segment pattern.
//   code : 0-9 digits, 10 dash, 15 (and any other unused code) blank
//   seg  : {g,f,e,d,c,b,a}, active-low
module seg7_decode
   import chess_display_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] seg
);

   always_comb begin
      seg = BLANK;
      if (code <= 4'd9)
         seg = SEG_LUT[code];
      else if (code == CODE_DASH)
         seg = DASH;
      else if (code == CODE_BLANK)
         seg = BLANK;
   end

endmodule

// File: rtl/timer_display_scan.sv
// timer_display_scan
//   Multiplexes both players' mm.ss onto the eight-digit display:
//   player A on digits 7..4, player B on 3..0. The running player's
//   minutes digit carries the decimal point; an expired player's digits
//   blink.
//   clk, rst_n           : system clock, async active-low reset
//   min_*/sec_*          : player times (TW bits each)
//   run_b                : 1 = player B running, 0 = player A
//   expired_a/expired_b  : player reached 00.00
//   an                   : anodes, active-low, one-hot-zero
//   seg                  : segments {g,f,e,d,c,b,a}, active-low
//   dp                   : decimal point, active-low
// REFRESH_DIV must be at least 2 so the blanked anode cycle can complete.
module timer_display_scan
   import chess_display_pkg::*;
#(
   parameter int unsigned REFRESH_DIV  = 100000,
   parameter int unsigned BLINK_FRAMES = 64,
   parameter int unsigned TW           = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [TW-1:0] min_a,
   input  logic [TW-1:0] sec_a,
   input  logic [TW-1:0] min_b,
   input  logic [TW-1:0] sec_b,
   input  logic          run_b,
   input  logic          expired_a,
   input  logic          expired_b,
   output logic [7:0]    an,
   output logic [6:0]    seg,
   output logic          dp
);

   localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [RW-1:0] R_LAST = RW'(REFRESH_DIV - 1);
   localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);

   logic [RW-1:0] rcnt;
   logic [FW-1:0] fcnt;
   logic [2:0]    idx;
   logic          blink;
   logic          tick;
   logic          an_pend;
   logic [7:0]    an_next;

   logic [TW-1:0] s_min_a, s_sec_a, s_min_b, s_sec_b;
   logic          s_run_b, s_exp_a, s_exp_b;

   digit_pos_e    pos;
   logic [7:0]    bcd_ma, bcd_sa, bcd_mb, bcd_sb;
   logic [3:0]    code;
   logic [6:0]    seg_dec;
   logic          blank_now;
   logic          dp_now;

   // {tens, units} decoder codes; values above 59 show dash on both digits.
   function automatic logic [7:0] to_bcd(input logic [TW-1:0] v);
      logic [31:0] x;
      logic [3:0]  t;
      logic [3:0]  u;
      x = 32'(v);
      if (x > 32'd59) begin
         t = CODE_DASH;
         u = CODE_DASH;
      end else if (x >= 32'd50) begin
         t = 4'd5;
         u = 4'(x - 32'd50);
      end else if (x >= 32'd40) begin
         t = 4'd4;
         u = 4'(x - 32'd40);
      end else if (x >= 32'd30) begin
         t = 4'd3;
         u = 4'(x - 32'd30);
      end else if (x >= 32'd20) begin
         t = 4'd2;
         u = 4'(x - 32'd20);
      end else if (x >= 32'd10) begin
         t = 4'd1;
         u = 4'(x - 32'd10);
      end else begin
         t = 4'd0;
         u = 4'(x);
      end
      return {t, u};
   endfunction

   assign tick = (rcnt == R_LAST);
   assign pos  = digit_pos_e'(idx);

   always_comb begin
      bcd_ma = to_bcd(s_min_a);
      bcd_sa = to_bcd(s_sec_a);
      bcd_mb = to_bcd(s_min_b);
      bcd_sb = to_bcd(s_sec_b);
      code   = CODE_BLANK;
      case (pos)
         DIG_A_MT: code = bcd_ma[7:4];
         DIG_A_MU: code = bcd_ma[3:0];
         DIG_A_ST: code = bcd_sa[7:4];
         DIG_A_SU: code = bcd_sa[3:0];
         DIG_B_MT: code = bcd_mb[7:4];
         DIG_B_MU: code = bcd_mb[3:0];
         DIG_B_ST: code = bcd_sb[7:4];
         DIG_B_SU: code = bcd_sb[3:0];
         default:  code = CODE_BLANK;
      endcase
      blank_now = blink & (idx[2] ? s_exp_a : s_exp_b);
      dp_now    = ~(((pos == DIG_A_MU) & ~s_run_b) |
                    ((pos == DIG_B_MU) &  s_run_b));
   end

   seg7_decode u_dec (
      .code (code),
      .seg  (seg_dec)
   );

   // On each tick the digit at idx is loaded into seg/dp with anodes
   // blanked; its anode follows one cycle later. idx then advances, and the
   // snapshot/frame counters roll over together with the 7 -> 0 wrap, so the
   // digit-7 load still uses the outgoing frame's snapshot and blink phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rcnt    <= '0;
         fcnt    <= '0;
         idx     <= '0;
         blink   <= 1'b0;
         an_pend <= 1'b0;
         an_next <= '1;
         an      <= '1;
         seg     <= BLANK;
         dp      <= 1'b1;
         s_min_a <= '0;
         s_sec_a <= '0;
         s_min_b <= '0;
         s_sec_b <= '0;
         s_run_b <= 1'b0;
         s_exp_a <= 1'b0;
         s_exp_b <= 1'b0;
      end else begin
         an_pend <= 1'b0;
         rcnt    <= tick ? '0 : rcnt + RW'(1);
         if (tick) begin
            an      <= '1;
            an_next <= ~(8'd1 << idx);
            an_pend <= 1'b1;
            seg     <= blank_now ? BLANK : seg_dec;
            dp      <= blank_now ? 1'b1 : dp_now;
            idx     <= idx + 3'd1;
            if (idx == 3'd7) begin
               s_min_a <= min_a;
               s_sec_a <= sec_a;
               s_min_b <= min_b;
               s_sec_b <= sec_b;
               s_run_b <= run_b;
               s_exp_a <= expired_a;
               s_exp_b <= expired_b;
               if (fcnt == F_LAST) begin
                  fcnt  <= '0;
                  blink <= ~blink;
               end else begin
                  fcnt <= fcnt + FW'(1);
               end
            end
         end else if (an_pend) begin
            an <= an_next;
         end
      end
   end

endmodule

// File: tb/tb_timer_display_scan.sv
module tb_timer_display_scan;

   localparam int unsigned DIV   = 4;
   localparam int unsigned BF    = 2;
   localparam int unsigned FRAME = 8 * DIV;
   localparam logic [6:0] SEGTAB [10] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

   typedef struct {
      int ma, sa, mb, sb;
      bit run, xa, xb;
   } snap_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   timer_display_scan_if #(.TW(6)) tif ();

   timer_display_scan #(
      .REFRESH_DIV  (DIV),
      .BLINK_FRAMES (BF),
      .TW           (6)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .min_a     (tif.min_a),
      .sec_a     (tif.sec_a),
      .min_b     (tif.min_b),
      .sec_b     (tif.sec_b),
      .run_b     (tif.run_b),
      .expired_a (tif.expired_a),
      .expired_b (tif.expired_b),
      .an        (tif.an),
      .seg       (tif.seg),
      .dp        (tif.dp)
   );

   int    assertions = 0;
   int    failures   = 0;
   int    k;            // clock edges since reset release
   int    cur_d;        // digit most recently loaded
   int    cur_f;        // frame number of that digit
   snap_t cur;          // values the current frame displays
   logic [7:0] exp_an, pend_an;
   logic [6:0] exp_seg;
   logic       exp_dp;

   // Expected {seg, dp} for digit d of frame f from the snapshot, using
   // decimal arithmetic on the player times.
   function automatic logic [7:0] model_digit(input int d, input int f);
      int v;
      bit pa;
      int q;
      logic [6:0] s;
      logic p;
      pa = (d >= 4);
      q  = d % 4;
      v  = pa ? ((q >= 2) ? cur.ma : cur.sa) : ((q >= 2) ? cur.mb : cur.sb);
      if (v > 59) s = 7'h3F;
      else        s = SEGTAB[(q % 2 == 1) ? v / 10 : v % 10];
      p = !((d == 6 && !cur.run) || (d == 2 && cur.run));
      if (((f / BF) % 2 == 1) && (pa ? cur.xa : cur.xb)) begin
         s = 7'h7F;
         p = 1'b1;
      end
      return {s, p};
   endfunction

   task automatic model_reset();
      k       = 0;
      cur_d   = 0;
      cur_f   = 0;
      cur     = '{default: 0};
      exp_an  = 8'hFF;
      pend_an = 8'hFF;
      exp_seg = 7'h7F;
      exp_dp  = 1'b1;
   endtask

   // One clock edge of the reference timeline, then back to the sampling edge.
   task automatic advance();
      int n;
      logic [7:0] sd;
      @(posedge clk);
      k++;
      if (k % DIV == 0) begin
         n       = k / DIV;
         cur_d   = (n - 1) % 8;
         cur_f   = (n - 1) / 8;
         sd      = model_digit(cur_d, cur_f);
         exp_seg = sd[7:1];
         exp_dp  = sd[0];
         exp_an  = 8'hFF;
         pend_an = ~(8'd1 << cur_d);
         if (cur_d == 7)
            cur = '{int'(tif.min_a), int'(tif.sec_a), int'(tif.min_b), int'(tif.sec_b),
                    tif.run_b, tif.expired_a, tif.expired_b};
      end else if (k % DIV == 1 && k > DIV) begin
         exp_an = pend_an;
      end
      @(negedge clk);
   endtask

   task automatic set_inputs(input int ma, sa, mb, sb, input bit run, xa, xb);
      tif.min_a     = 6'(ma);
      tif.sec_a     = 6'(sa);
      tif.min_b     = 6'(mb);
      tif.sec_b     = 6'(sb);
      tif.run_b     = run;
      tif.expired_a = xa;
      tif.expired_b = xb;
   endtask

   task automatic test_reset();
      set_inputs(0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         assertions++;
         if ({tif.an, tif.seg, tif.dp} !== {8'hFF, 7'h7F, 1'b1}) begin
            failures++;
            $display("FAIL reset_hold an=%h seg=%h dp=%b required an=ff seg=7f dp=1",
                     tif.an, tif.seg, tif.dp);
         end
      end
      rst_n = 1'b1;
      model_reset();
      repeat (DIV + 1) begin
         advance();
         assertions++;
         if ({tif.an, tif.seg, tif.dp} !== {exp_an, exp_seg, exp_dp}) begin
            failures++;
            $display("FAIL reset_release k=%0d an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                     k, tif.an, tif.seg, tif.dp, exp_an, exp_seg, exp_dp);
         end
      end
      assertions++;
      if (tif.an !== 8'hFE) begin
         failures++;
         $display("FAIL first_anode an=%h required fe", tif.an);
      end
   endtask

   task automatic test_frame_pattern();
      logic [6:0] pat [8];
      pat = '{7'h10, 7'h40, 7'h12, 7'h40, 7'h19, 7'h30, 7'h24, 7'h79};  // digit 0..7
      set_inputs(12, 34, 5, 9, 0, 0, 0);
      repeat (3 * FRAME) begin
         advance();
         assertions++;
         if ({tif.an, tif.seg, tif.dp} !== {exp_an, exp_seg, exp_dp}) begin
            failures++;
            $display("FAIL frame_pattern k=%0d an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                     k, tif.an, tif.seg, tif.dp, exp_an, exp_seg, exp_dp);
         end
         if (k % DIV == 1 && cur_f == 1) begin
            assertions++;
            if ({tif.seg, tif.dp} !== {pat[cur_d], (cur_d == 6) ? 1'b0 : 1'b1}) begin
               failures++;
               $display("FAIL frame_table digit=%0d seg=%h dp=%b required seg=%h dp=%b",
                        cur_d, tif.seg, tif.dp, pat[cur_d], (cur_d == 6) ? 1'b0 : 1'b1);
            end
         end
      end
   endtask

   task automatic test_snapshot();
      int f0;
      while (k % FRAME != 12) advance();
      f0 = cur_f;
      tif.sec_a = 6'd33;
      repeat (2 * FRAME) begin
         advance();
         assertions++;
         if ({tif.an, tif.seg, tif.dp} !== {exp_an, exp_seg, exp_dp}) begin
            failures++;
            $display("FAIL snapshot k=%0d an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                     k, tif.an, tif.seg, tif.dp, exp_an, exp_seg, exp_dp);
         end
         if (k % DIV == 1 && cur_d == 4 && cur_f <= f0 + 1) begin
            assertions++;
            if (tif.seg !== ((cur_f == f0) ? 7'h19 : 7'h30)) begin
               failures++;
               $display("FAIL snapshot_units frame=%0d seg=%h required %h",
                        cur_f, tif.seg, (cur_f == f0) ? 7'h19 : 7'h30);
            end
         end
      end
   endtask

   task automatic test_dash();
      int f0;
      f0 = cur_f;
      set_inputs(12, 33, 5, 60, 1, 0, 0);
      repeat (2 * FRAME + DIV) begin
         advance();
         assertions++;
         if ({tif.an, tif.seg, tif.dp} !== {exp_an, exp_seg, exp_dp}) begin
            failures++;
            $display("FAIL dash k=%0d an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                     k, tif.an, tif.seg, tif.dp, exp_an, exp_seg, exp_dp);
         end
         if (k % DIV == 1 && cur_f == f0 + 1 && cur_d <= 1) begin
            assertions++;
            if (tif.seg !== 7'h3F) begin
               failures++;
               $display("FAIL dash_digit digit=%0d seg=%h required 3f", cur_d, tif.seg);
            end
         end
      end
   endtask

   task automatic test_blink();
      set_inputs(3, 7, 4, 15, 0, 1, 0);
      repeat (5 * FRAME) begin
         advance();
         assertions++;
         if ({tif.an, tif.seg, tif.dp} !== {exp_an, exp_seg, exp_dp}) begin
            failures++;
            $display("FAIL blink_a k=%0d an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                     k, tif.an, tif.seg, tif.dp, exp_an, exp_seg, exp_dp);
         end
      end
      set_inputs(0, 0, 0, 0, 1, 1, 1);
      repeat (5 * FRAME) begin
         advance();
         assertions++;
         if ({tif.an, tif.seg, tif.dp} !== {exp_an, exp_seg, exp_dp}) begin
            failures++;
            $display("FAIL blink_both k=%0d an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                     k, tif.an, tif.seg, tif.dp, exp_an, exp_seg, exp_dp);
         end
      end
   endtask

   task automatic test_random();
      repeat (8 * FRAME) begin
         if ($urandom_range(0, 7) == 0)
            set_inputs($urandom_range(0, 63), $urandom_range(0, 63),
                       $urandom_range(0, 63), $urandom_range(0, 63),
                       1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 3) == 0));
         advance();
         assertions++;
         if ({tif.an, tif.seg, tif.dp} !== {exp_an, exp_seg, exp_dp}) begin
            failures++;
            $display("FAIL random k=%0d an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                     k, tif.an, tif.seg, tif.dp, exp_an, exp_seg, exp_dp);
         end
      end
   endtask

   task automatic test_async_reset();
      set_inputs(21, 45, 9, 8, 1, 0, 0);
      while (k % FRAME != 18) advance();
      #2 rst_n = 1'b0;
      #1;
      assertions++;
      if ({tif.an, tif.seg, tif.dp} !== {8'hFF, 7'h7F, 1'b1}) begin
         failures++;
         $display("FAIL async_reset an=%h seg=%h dp=%b required an=ff seg=7f dp=1",
                  tif.an, tif.seg, tif.dp);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (FRAME + FRAME / 2) begin
         advance();
         assertions++;
         if ({tif.an, tif.seg, tif.dp} !== {exp_an, exp_seg, exp_dp}) begin
            failures++;
            $display("FAIL after_reset k=%0d an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                     k, tif.an, tif.seg, tif.dp, exp_an, exp_seg, exp_dp);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_frame_pattern();
      test_snapshot();
      test_dash();
      test_blink();
      test_random();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

endmodule
